// File: rtl/imem_pkg.sv
// Shared constants, mode encoding and byte-to-word index macro for the instruction-memory arbiter.
package imem_pkg;

    localparam int DEFAULT_DEPTH        = 256;
    localparam int DEFAULT_ADDR_W       = 8;
    localparam int DEFAULT_STARVE_LIMIT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_e;

endpackage

`ifndef IMEM_BYTE2WORD
// Word index of a byte address; bits above the memory range and the byte offset are dropped.
`define IMEM_BYTE2WORD(addr, aw) addr[(aw)+1:2]
`endif

// File: rtl/imem_arbiter_if.sv
// Loader, fetch, debug and memory-port signals of the instruction-memory arbiter.
interface imem_arbiter_if #(
    parameter int ADDR_W = imem_pkg::DEFAULT_ADDR_W
);
    logic              load_start;
    logic              load_valid;
    logic [31:0]       load_data;
    logic              load_last;
    logic              load_ready;
    logic              fetch_req;
    logic [31:0]       fetch_addr;
    logic              fetch_grant;
    logic              fetch_valid;
    logic [31:0]       fetch_instr;
    logic              dbg_req;
    logic [31:0]       dbg_addr;
    logic              dbg_grant;
    logic              dbg_valid;
    logic [31:0]       dbg_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  load_start, load_valid, load_data, load_last,
        input  fetch_req, fetch_addr, dbg_req, dbg_addr, mem_rdata,
        output load_ready, fetch_grant, fetch_valid, fetch_instr,
        output dbg_grant, dbg_valid, dbg_data, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output load_start, load_valid, load_data, load_last,
        output fetch_req, fetch_addr, dbg_req, dbg_addr, mem_rdata,
        input  load_ready, fetch_grant, fetch_valid, fetch_instr,
        input  dbg_grant, dbg_valid, dbg_data, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_rr_starve.sv
// Fetch/debug priority picker: fetch wins unless debug has lost STARVE_LIMIT cycles in a row.
module imem_rr_starve import imem_pkg::*; #(
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic fetch_req,
    input  logic dbg_req,
    output logic fetch_grant,
    output logic dbg_grant
);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        dbg_grant   = en & dbg_req & ((cnt_q == CNT_W'(STARVE_LIMIT)) | ~fetch_req);
        fetch_grant = en & fetch_req & ~dbg_grant;
        cnt_d       = '0;
        if (en && dbg_req && !dbg_grant) cnt_d = cnt_q + 1'b1;
    end

    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/imem_arbiter.sv
// Single-port instruction-memory arbiter with IDLE/LOAD/RUN mode FSM.
// Optional debug read port enabled by defining IMEM_DBG_PORT_EN.
module imem_arbiter import imem_pkg::*; #(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = DEFAULT_ADDR_W
`ifdef IMEM_DBG_PORT_EN
    , parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
`endif
) (
    input  logic           clk,
    input  logic           rst_n,
    imem_arbiter_if.slave  bus,
    output logic           cpu_run,
    output logic           load_overflow
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              overflow_q, overflow_d;
    logic              cpu_run_q, cpu_run_d;
    logic              fetch_valid_q;
    logic [31:0]       fetch_instr_q, fetch_instr_d;
    logic              run, load_acc, fetch_win, dbg_win;
    logic              unused_bits;

    assign run      = (state_q == RUN);
    assign load_acc = (state_q == LOAD) & bus.load_valid;

`ifdef IMEM_DBG_PORT_EN
    imem_rr_starve #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (run),
        .fetch_req   (bus.fetch_req),
        .dbg_req     (bus.dbg_req),
        .fetch_grant (fetch_win),
        .dbg_grant   (dbg_win)
    );
    assign unused_bits = ^{bus.fetch_addr[31:ADDR_W+2], bus.fetch_addr[1:0],
                           bus.dbg_addr[31:ADDR_W+2], bus.dbg_addr[1:0]};
`else
    assign fetch_win   = run & bus.fetch_req;
    assign dbg_win     = 1'b0;
    assign unused_bits = ^{bus.fetch_addr[31:ADDR_W+2], bus.fetch_addr[1:0],
                           bus.dbg_req, bus.dbg_addr};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        overflow_d = overflow_q;
        unique case (state_q)
            IDLE: state_d = IDLE;
            LOAD: begin
                if (load_acc) begin
                    wptr_d = wptr_q + 1'b1;
                    if (bus.load_last) begin
                        state_d = RUN;
                    end else if (wptr_q == ADDR_W'(DEPTH - 1)) begin
                        state_d    = RUN;
                        overflow_d = 1'b1;
                    end
                end
            end
            RUN:     state_d = RUN;
            default: state_d = IDLE;
        endcase
        // A (re)load always restarts the image at word 0, from any mode.
        if (bus.load_start) begin
            state_d = LOAD;
            wptr_d  = '0;
        end
    end

    always_comb begin
        bus.load_ready  = (state_q == LOAD);
        bus.mem_we      = load_acc;
        bus.mem_wdata   = '0;
        bus.fetch_grant = fetch_win;
        bus.dbg_grant   = dbg_win;
        mem_addr_d      = mem_addr_q;
        if (load_acc) begin
            mem_addr_d    = wptr_q;
            bus.mem_wdata = bus.load_data;
        end else if (fetch_win) begin
            mem_addr_d = `IMEM_BYTE2WORD(bus.fetch_addr, ADDR_W);
        end else if (dbg_win) begin
            mem_addr_d = `IMEM_BYTE2WORD(bus.dbg_addr, ADDR_W);
        end
        bus.mem_addr = mem_addr_d;
    end

    // cpu_run rises one cycle into RUN but falls in the very cycle after load_start.
    assign cpu_run_d     = run & (state_d == RUN);
    assign fetch_instr_d = fetch_win ? bus.mem_rdata : fetch_instr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q        <= '0;
            mem_addr_q    <= '0;
            overflow_q    <= 1'b0;
            cpu_run_q     <= 1'b0;
            fetch_valid_q <= 1'b0;
            fetch_instr_q <= '0;
        end else begin
            wptr_q        <= wptr_d;
            mem_addr_q    <= mem_addr_d;
            overflow_q    <= overflow_d;
            cpu_run_q     <= cpu_run_d;
            fetch_valid_q <= fetch_win;
            fetch_instr_q <= fetch_instr_d;
        end
    end

    assign cpu_run         = cpu_run_q;
    assign load_overflow   = overflow_q;
    assign bus.fetch_valid = fetch_valid_q;
    assign bus.fetch_instr = fetch_instr_q;

`ifdef IMEM_DBG_PORT_EN
    logic        dbg_valid_q;
    logic [31:0] dbg_data_q, dbg_data_d;

    assign dbg_data_d = dbg_win ? bus.mem_rdata : dbg_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbg_valid_q <= 1'b0;
            dbg_data_q  <= '0;
        end else begin
            dbg_valid_q <= dbg_win;
            dbg_data_q  <= dbg_data_d;
        end
    end

    assign bus.dbg_valid = dbg_valid_q;
    assign bus.dbg_data  = dbg_data_q;
`else
    assign bus.dbg_valid = 1'b0;
    assign bus.dbg_data  = '0;
`endif
endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: table-driven fetch vectors, hand-written corner sequences and a
// randomized RUN phase scored against a behavioural model of the arbitration rules.
module tb_imem_arbiter;
    localparam int STARVE_LIMIT = 4;
`ifdef IMEM_DBG_PORT_EN
    localparam bit DBG_EN = 1'b1;
`else
    localparam bit DBG_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  idx;
        logic [31:0] instr;
    } fetch_vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic cpu_run, load_overflow;
    int   checks = 0;
    int   failures = 0;

    imem_arbiter_if #(.ADDR_W(8)) bus ();

    imem_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .cpu_run       (cpu_run),
        .load_overflow (load_overflow)
    );

    always #5 clk = ~clk;

    // Memory behind the port: synchronous write, combinational read.
    logic [31:0] mem [256];
    always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    assign bus.mem_rdata = mem[bus.mem_addr];

    logic [31:0] img [256];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.load_start = 0; bus.load_valid = 0; bus.load_data = 0; bus.load_last = 0;
        bus.fetch_req = 0; bus.fetch_addr = 0; bus.dbg_req = 0; bus.dbg_addr = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        fetch_vec_t  vecs [6];
        logic [31:0] words [4];
        logic [31:0] first_word, fa, da;
        logic [31:0] exp_fi, exp_di;
        logic [7:0]  exp_maddr;
        logic        fr, dr, fwin, dwin, exp_fv, exp_dv;
        int          starve;

        words = '{32'hFC000000, 32'hFC200004, 32'h00400C00, 32'h08620C00};
        vecs[0] = '{32'h0000_0008, 8'd2, 32'h00400C00};
        vecs[1] = '{32'h0000_040C, 8'd3, 32'h08620C00};
        vecs[2] = '{32'h0000_0000, 8'd0, 32'hFC000000};
        vecs[3] = '{32'h0000_0005, 8'd1, 32'hFC200004};
        vecs[4] = '{32'hABCD_E403, 8'd0, 32'hFC000000};
        vecs[5] = '{32'hFFFF_FC0E, 8'd3, 32'h08620C00};

        clear_inputs();
        rst_n = 0;
        settle();
        check("rst cpu_run", cpu_run, 0);
        check("rst load_ready", bus.load_ready, 0);
        check("rst overflow", load_overflow, 0);
        check("rst fetch_valid", bus.fetch_valid, 0);
        check("rst mem_addr", bus.mem_addr, 0);
        check("rst dbg_valid", bus.dbg_valid, 0);
        rst_n = 1;
        tick();

        // Load a four-word image.
        bus.load_start = 1;
        settle();
        check("idle load_ready", bus.load_ready, 0);
        tick();
        bus.load_start = 0;
        for (int i = 0; i < 4; i++) begin
            bus.load_valid = 1; bus.load_data = words[i]; bus.load_last = (i == 3);
            settle();
            check("load mem_we", bus.mem_we, 1);
            check("load mem_addr", bus.mem_addr, i);
            check("load mem_wdata", bus.mem_wdata, words[i]);
            check("load ready", bus.load_ready, 1);
            check("load cpu_run", cpu_run, 0);
            img[i] = words[i];
            tick();
        end
        clear_inputs();
        settle();
        check("run+1 cpu_run", cpu_run, 0);
        check("run+1 load_ready", bus.load_ready, 0);
        tick();
        settle();
        check("run+2 cpu_run", cpu_run, 1);
        check("run overflow", load_overflow, 0);
        tick();

        // Table of fetch addresses: truncation of high and low bits.
        for (int v = 0; v < 6; v++) begin
            bus.fetch_req = 1; bus.fetch_addr = vecs[v].addr;
            settle();
            check("vec fetch_grant", bus.fetch_grant, 1);
            check("vec mem_addr", bus.mem_addr, vecs[v].idx);
            tick();
            bus.fetch_req = 0; bus.fetch_addr = $urandom;
            settle();
            check("vec fetch_valid", bus.fetch_valid, 1);
            check("vec fetch_instr", bus.fetch_instr, vecs[v].instr);
            check("vec mem_addr hold", bus.mem_addr, vecs[v].idx);
            tick();
            settle();
            check("vec valid pulse", bus.fetch_valid, 0);
            check("vec instr hold", bus.fetch_instr, vecs[v].instr);
            tick();
        end

        // Debug starvation: fetch held high, debug forced through on the fifth cycle.
        bus.fetch_req = 1; bus.fetch_addr = 0; bus.dbg_req = 1; bus.dbg_addr = 32'h4;
        for (int i = 0; i < 6; i++) begin
            settle();
            check("starve fetch_grant", bus.fetch_grant, !(DBG_EN && i == 4));
            check("starve dbg_grant", bus.dbg_grant, DBG_EN && i == 4);
            check("starve dbg_valid", bus.dbg_valid, DBG_EN && i == 5);
            check("starve dbg_data", bus.dbg_data, (DBG_EN && i == 5) ? 32'hFC200004 : 32'h0);
            tick();
        end
        clear_inputs();

        // Overflowing image: 257 words offered without load_last.
        bus.load_start = 1;
        settle();
        check("reload cpu_run still high", cpu_run, 1);
        tick();
        bus.load_start = 0;
        for (int i = 0; i <= 256; i++) begin
            bus.load_valid = 1; bus.load_data = $urandom; bus.load_last = 0;
            settle();
            check("ovf mem_we", bus.mem_we, i < 256);
            check("ovf load_ready", bus.load_ready, i < 256);
            check("ovf flag", load_overflow, i == 256);
            if (i < 256) begin
                check("ovf mem_addr", bus.mem_addr, i);
                img[i] = bus.load_data;
            end
            tick();
        end
        first_word = img[0];
        clear_inputs();
        settle();
        check("ovf cpu_run", cpu_run, 1);
        check("ovf state run", bus.load_ready, 0);
        tick();
        bus.fetch_req = 1; bus.fetch_addr = 0;
        settle();
        check("ovf fetch grant", bus.fetch_grant, 1);
        tick();
        bus.fetch_req = 0;
        settle();
        check("ovf index0 word1", bus.fetch_instr, first_word);
        tick();

        // Randomized RUN traffic against the arbitration model.
        starve = 0; exp_fv = 0; exp_dv = 0; exp_fi = first_word;
        exp_di = DBG_EN ? 32'hFC200004 : 32'h0; exp_maddr = 0;
        for (int c = 0; c < 300; c++) begin
            fr = ($urandom_range(0, 4) != 0);
            dr = ($urandom_range(0, 3) != 0);
            fa = $urandom; da = $urandom;
            bus.fetch_req = fr; bus.fetch_addr = fa; bus.dbg_req = dr; bus.dbg_addr = da;
            settle();
            dwin = DBG_EN && dr && (starve == STARVE_LIMIT || !fr);
            fwin = fr && !dwin;
            if (fwin)      exp_maddr = 8'((fa >> 2) % 256);
            else if (dwin) exp_maddr = 8'((da >> 2) % 256);
            check("rnd fetch_grant", bus.fetch_grant, fwin);
            check("rnd dbg_grant", bus.dbg_grant, dwin);
            check("rnd mem_addr", bus.mem_addr, exp_maddr);
            check("rnd mem_we", bus.mem_we, 0);
            check("rnd fetch_valid", bus.fetch_valid, exp_fv);
            check("rnd fetch_instr", bus.fetch_instr, exp_fi);
            check("rnd dbg_valid", bus.dbg_valid, exp_dv);
            check("rnd dbg_data", bus.dbg_data, exp_di);
            exp_fv = fwin;
            exp_dv = dwin;
            if (fwin) exp_fi = img[(fa >> 2) % 256];
            if (dwin) exp_di = img[(da >> 2) % 256];
            starve = (dr && !dwin) ? starve + 1 : 0;
            tick();
        end
        clear_inputs();
        tick();

        // load_start in the same cycle as a fetch grant.
        bus.fetch_req = 1; bus.fetch_addr = 32'h8; bus.load_start = 1;
        settle();
        check("ls fetch_grant", bus.fetch_grant, 1);
        check("ls cpu_run", cpu_run, 1);
        tick();
        clear_inputs();
        settle();
        check("ls fetch_valid", bus.fetch_valid, 1);
        check("ls fetch_instr", bus.fetch_instr, img[2]);
        check("ls cpu_run drop", cpu_run, 0);
        check("ls load_ready", bus.load_ready, 1);
        tick();
        bus.load_valid = 1; bus.load_data = 32'h12345678; bus.fetch_req = 1;
        settle();
        check("ls wptr restart", bus.mem_addr, 0);
        check("ls mem_we", bus.mem_we, 1);
        check("ls no grant in load", bus.fetch_grant, 0);
        tick();
        bus.load_data = 32'h9ABCDEF0;
        settle();
        check("ls second word", bus.mem_addr, 1);

        // Asynchronous reset mid-LOAD, no clock edge needed.
        #1 rst_n = 0;
        #1;
        check("arst load_ready", bus.load_ready, 0);
        check("arst mem_we", bus.mem_we, 0);
        check("arst mem_addr", bus.mem_addr, 0);
        check("arst mem_wdata", bus.mem_wdata, 0);
        check("arst cpu_run", cpu_run, 0);
        check("arst overflow", load_overflow, 0);
        check("arst fetch_valid", bus.fetch_valid, 0);
        check("arst fetch_instr", bus.fetch_instr, 0);
        clear_inputs();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Owns the single port of the 256x32 instruction memory.
- Shares the port between three requesters:
  - a program loader, which streams words in after reset or on reload;
  - the core's fetch stage;
  - a debug read port.
- Sequences the CPU lifecycle with a three-state mode FSM (IDLE -> LOAD -> RUN) and releases the core through cpu_run.
- Memory read is combinational. The arbiter registers read data, so requesters see a fixed one-cycle latency.

Parameters:
DEPTH, 256, number of 32-bit words in instruction memory (power of two)
ADDR_W, 8, word-index width, log2(DEPTH)
STARVE_LIMIT, 4, consecutive RUN cycles a pending debug request may lose to fetch before it is forced through

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
load_start  input  1  pulse: enter LOAD, halt core
load_valid  input  1  loader word valid
load_data  input  32  loader word
load_last  input  1  qualifies final word of image
load_ready  output  1  loader handshake ready
fetch_req  input  1  fetch request
fetch_addr  input  32  byte address of instruction
fetch_grant  output  1  fetch accepted this cycle
fetch_valid  output  1  fetch_instr valid
fetch_instr  output  32  registered instruction
dbg_req  input  1  debug read request
dbg_addr  input  32  debug byte address
dbg_grant  output  1  debug accepted this cycle
dbg_valid  output  1  dbg_data valid
dbg_data  output  32  registered debug read data
mem_we  output  1  memory write enable
mem_addr  output  ADDR_W  memory word index
mem_wdata  output  32  memory write data
mem_rdata  input  32  memory combinational read data
cpu_run  output  1  high = core released from hold
load_overflow  output  1  sticky: image exceeded DEPTH words

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all outputs 0.
  - Write pointer wptr=0; starve counter=0.
- State IDLE:
  - cpu_run=0; no grants.
  - load_start -> LOAD.
- State LOAD:
  - load_ready=1 and cpu_run=0; fetch/debug never granted.
  - Write accepted when load_valid&load_ready: mem_we=1, mem_addr=wptr, mem_wdata=load_data, all in the same cycle; wptr increments.
  - Accepted word with load_last=1 -> RUN next cycle.
  - Accepted word at wptr=DEPTH-1 without load_last -> load_overflow set (sticky until reset), wptr wraps to 0, -> RUN.
  - load_start while in LOAD: wptr restarts at 0; a write accepted in that same cycle still lands.
- Entering LOAD from any state: wptr cleared to 0.
- State RUN:
  - cpu_run=1 (registered; asserts the cycle after the transition).
  - load_start -> LOAD next cycle. In that same cycle cpu_run is still 1; it drops the following cycle.
  - A grant issued in the load_start cycle still completes its valid pulse.
- RUN arbitration: one grant per cycle; mem_we=0.
  - Fetch wins over debug by default.
  - Starve counter increments each cycle dbg_req is high and loses; it clears on dbg_grant or when dbg_req is low.
  - Counter==STARVE_LIMIT -> debug wins that cycle even if fetch_req=1.
  - Grant sets mem_addr=addr[ADDR_W+1:2]; address bits above ADDR_W+1 are ignored.
  - Misaligned addr[1:0] is ignored (word-truncated).
- Latency:
  - Grant in cycle N -> *_valid=1 with registered mem_rdata in cycle N+1, for exactly one cycle.
  - *_instr/*_data hold the last value when valid is 0.
- No request or no grant -> mem_addr holds its previous value.

Optional Feature:
- IMEM_DBG_PORT_EN.
- Defined: debug port behaves as above.
- Undefined: dbg_grant, dbg_valid and dbg_data are tied to 0, the starve counter is removed, and fetch always wins in RUN.

Decomposition:
- Package imem_pkg holds:
  - state encoding constants IDLE=2'd0, LOAD=2'd1, RUN=2'd2;
  - default DEPTH and ADDR_W;
  - the byte-to-word index macro.
- One natural sub-module, imem_rr_starve: the fetch/debug priority picker with starve counter, instantiated only under IMEM_DBG_PORT_EN.

Test Plan:
- Reset, then load_start; stream 4 words 0xFC000000, 0xFC200004, 0x00400C00, 0x08620C00 with load_last on the 4th -> mem writes at indices 0..3; cpu_run=1 two cycles after the last accept; load_overflow=0.
- RUN, fetch_req with fetch_addr=0x8 -> fetch_grant that cycle; next cycle fetch_valid=1, fetch_instr=0x00400C00. fetch_addr=0x40C maps to index 3.
- RUN, fetch_req held high and dbg_req high at dbg_addr=0x4 -> fetch granted 4 cycles; 5th cycle dbg_grant=1; the following cycle dbg_data=0xFC200004.
- LOAD with 257 words and no load_last -> load_overflow=1 after word 256; state RUN; word 257 is accepted in RUN? No: load_ready=0 in RUN, so it is not accepted; index 0 holds word 1.
- load_start asserted mid-RUN while a fetch is granted -> that fetch's valid pulse still appears; cpu_run drops the cycle after; wptr=0.
- rst_n pulsed low mid-LOAD -> immediately IDLE, all outputs 0, load_ready=0.
